// File: rtl/score_display_ctrl.sv
// Game-level controller feeding the four digits of the seven-segment multiplexer:
// BCD score / high score, IDLE/PLAY/OVER sequencing and game-over blinking.
module score_display_ctrl #(
  parameter int BLINK_DIV = 25000000,
  parameter int CW        = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       score_inc,
  input  logic       game_over,
  output logic [3:0] num_1,
  output logic [3:0] num_2,
  output logic [3:0] num_3,
  output logic [3:0] num_4,
  output logic       playing,
  output logic       new_record
);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  localparam logic [3:0]    BLANK      = 4'hF;
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);

  state_t        state_q, state_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    hi_q, hi_d;
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic          new_record_q, new_record_d;
  logic [3:0]    num_1_q, num_1_d;
  logic [3:0]    num_2_q, num_2_d;
  logic [3:0]    num_3_q, num_3_d;
  logic [3:0]    num_4_q, num_4_d;
  logic          playing_q, playing_d;
  logic [7:0]    score_inc_val;

  // Two-digit BCD increment that sticks at 99 instead of wrapping.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  always_comb begin
    state_d       = state_q;
    score_d       = score_q;
    hi_d          = hi_q;
    blink_cnt_d   = blink_cnt_q;
    blink_on_d    = blink_on_q;
    new_record_d  = new_record_q;
    score_inc_val = score_inc ? bcd_inc_sat(score_q) : score_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PLAY;
          score_d = 8'h00;
        end
      end
      PLAY: begin
        score_d = score_inc_val;
        if (game_over) begin
          state_d     = OVER;
          blink_cnt_d = '0;
          blink_on_d  = 1'b1;
          // BCD digits compare correctly as a plain unsigned byte.
          if (score_inc_val > hi_q) begin
            hi_d         = score_inc_val;
            new_record_d = 1'b1;
          end else begin
            new_record_d = 1'b0;
          end
        end
      end
      OVER: begin
        if (start) begin
          state_d      = PLAY;
          score_d      = 8'h00;
          new_record_d = 1'b0;
          blink_cnt_d  = '0;
          blink_on_d   = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = '0;
          blink_on_d  = ~blink_on_q;
        end else begin
          blink_cnt_d = blink_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next-state values so the registered outputs
  // always match the registered state.
  always_comb begin
    num_1_d   = BLANK;
    num_2_d   = BLANK;
    num_3_d   = hi_d[7:4];
    num_4_d   = hi_d[3:0];
    playing_d = (state_d == PLAY);
    case (state_d)
      PLAY: begin
        num_1_d = score_d[7:4];
        num_2_d = score_d[3:0];
      end
      OVER: begin
        if (blink_on_d) begin
          num_1_d = score_d[7:4];
          num_2_d = score_d[3:0];
        end else if (new_record_d) begin
          num_3_d = BLANK;
          num_4_d = BLANK;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      score_q      <= 8'h00;
      hi_q         <= 8'h00;
      blink_cnt_q  <= '0;
      blink_on_q   <= 1'b1;
      new_record_q <= 1'b0;
      num_1_q      <= BLANK;
      num_2_q      <= BLANK;
      num_3_q      <= 4'h0;
      num_4_q      <= 4'h0;
      playing_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      hi_q         <= hi_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      new_record_q <= new_record_d;
      num_1_q      <= num_1_d;
      num_2_q      <= num_2_d;
      num_3_q      <= num_3_d;
      num_4_q      <= num_4_d;
      playing_q    <= playing_d;
    end
  end

  assign num_1      = num_1_q;
  assign num_2      = num_2_q;
  assign num_3      = num_3_q;
  assign num_4      = num_4_q;
  assign playing    = playing_q;
  assign new_record = new_record_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench for score_display_ctrl: a behavioural game model predicts the
// outputs for every driven cycle; predictions are queued and compared after the edge.
module tb_score_display_ctrl;

  localparam int BLINK_DIV = 4;
  localparam int CW        = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, score_inc = 1'b0, game_over = 1'b0;
  logic [3:0] num_1, num_2, num_3, num_4;
  logic       playing, new_record;

  score_display_ctrl #(.BLINK_DIV(BLINK_DIV), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .score_inc(score_inc), .game_over(game_over),
    .num_1(num_1), .num_2(num_2), .num_3(num_3), .num_4(num_4),
    .playing(playing), .new_record(new_record)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] n1, n2, n3, n4;
    logic       pl, nr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Independent game model: 0 = IDLE, 1 = PLAY, 2 = OVER.
  int m_st, m_score, m_hi, m_cnt;
  bit m_bon, m_nr;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.n1 = 4'hF; e.n2 = 4'hF;
    e.n3 = 4'(m_hi / 10); e.n4 = 4'(m_hi % 10);
    e.pl = (m_st == 1);
    e.nr = m_nr;
    if (m_st == 1 || (m_st == 2 && m_bon)) begin
      e.n1 = 4'(m_score / 10); e.n2 = 4'(m_score % 10);
    end
    if (m_st == 2 && m_nr && !m_bon) begin
      e.n3 = 4'hF; e.n4 = 4'hF;
    end
    return e;
  endfunction

  function automatic void model_reset();
    m_st = 0; m_score = 0; m_hi = 0; m_cnt = 0; m_bon = 1; m_nr = 0;
  endfunction

  function automatic void model_step(input bit s, input bit i, input bit g);
    int sc;
    case (m_st)
      0: if (s) begin m_st = 1; m_score = 0; end
      1: begin
        sc = (i && m_score < 99) ? m_score + 1 : m_score;
        m_score = sc;
        if (g) begin
          m_st = 2; m_cnt = 0; m_bon = 1;
          if (sc > m_hi) begin m_hi = sc; m_nr = 1; end
          else m_nr = 0;
        end
      end
      default: begin
        if (s) begin
          m_st = 1; m_score = 0; m_nr = 0; m_cnt = 0; m_bon = 1;
        end else if (m_cnt == BLINK_DIV - 1) begin
          m_cnt = 0; m_bon = !m_bon;
        end else begin
          m_cnt++;
        end
      end
    endcase
  endfunction

  task automatic compare(input string tag, input exp_t e);
    check({tag, ".num_1"}, num_1, e.n1);
    check({tag, ".num_2"}, num_2, e.n2);
    check({tag, ".num_3"}, num_3, e.n3);
    check({tag, ".num_4"}, num_4, e.n4);
    check({tag, ".playing"}, playing, e.pl);
    check({tag, ".new_record"}, new_record, e.nr);
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge.
  task automatic step(input string tag, input bit s, input bit i, input bit g);
    exp_t e;
    start = s; score_inc = i; game_over = g;
    model_step(s, i, g);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    start = 1'b0; score_inc = 1'b0; game_over = 1'b0;
    if (exp_q.size() == 0) begin
      check({tag, ".queue_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      compare(tag, e);
    end
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag, 0, 0, 0);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare(tag, model_out());
    check({tag, ".lit_n1"}, num_1, 15);
    check({tag, ".lit_n3"}, num_3, 0);
    #1 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Mid-cycle async reset, then first game.
    async_reset("rst0");
    step("start", 1, 0, 0);
    for (int k = 0; k < 12; k++) step("inc12", 0, 1, 0);
    step("go12", 0, 0, 1);
    idle_cycles("blink12", 18);

    // Second game below the record: hi steady, score blinks.
    step("start2", 1, 0, 0);
    for (int k = 0; k < 5; k++) step("inc5", 0, 1, 0);
    step("go5", 0, 0, 1);
    idle_cycles("blink5", 10);

    // Post-increment comparison: hi 07, then 07 + inc with game_over.
    async_reset("rst1");
    step("start3", 1, 0, 0);
    for (int k = 0; k < 7; k++) step("inc7", 0, 1, 0);
    step("go7", 0, 0, 1);
    step("start4", 1, 0, 0);
    for (int k = 0; k < 7; k++) step("inc7b", 0, 1, 0);
    step("incgo", 0, 1, 1);
    idle_cycles("blink8", 6);

    // Ignored stimulus per state, with start winning in IDLE/OVER.
    async_reset("rst2");
    step("idle_inc", 0, 1, 0);
    step("idle_go", 0, 0, 1);
    step("idle_start_go", 1, 1, 1);
    step("play_start", 1, 0, 0);
    step("play_start_inc", 1, 1, 0);
    step("go_over", 0, 0, 1);
    step("over_inc", 0, 1, 0);
    step("over_go", 0, 0, 1);
    idle_cycles("over_wait", 3);
    step("over_start", 1, 1, 1);
    idle_cycles("play_steady", 10);

    // Carry and saturation: 0..99 plus three extra pulses.
    for (int k = 0; k < 102; k++) step("inc99", 0, 1, 0);
    step("go99", 0, 0, 1);
    idle_cycles("blink99", 9);

    // Reset mid-game clears the high score too.
    step("start5", 1, 0, 0);
    step("inc1", 0, 1, 0);
    async_reset("rst3");
    step("after_rst", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
Game-level controller that sequences the four digit inputs of the seven-segment display multiplexer. It keeps the current score and the high score as 2-digit BCD counters and runs an IDLE/PLAY/OVER state machine. In OVER it blinks the digits. It sits between game logic (start, score and game-over pulses) and the display multiplexer's num_1..num_4 inputs. Nibble 4'hF is the blank code for a digit.

Parameters:
BLINK_DIV, 25000000, clk cycles per blink half-period in OVER (0.25 s at 100 MHz); must be >= 2.
CW, 25, width of the blink counter; must satisfy 2^CW >= BLINK_DIV.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse: begin a new game.
score_inc  input  1  one-cycle pulse: add one point.
game_over  input  1  one-cycle pulse: current game ended.
num_1  output  4  score tens digit, or 4'hF for blank.
num_2  output  4  score ones digit, or 4'hF for blank.
num_3  output  4  high-score tens digit, or 4'hF for blank.
num_4  output  4  high-score ones digit, or 4'hF for blank.
playing  output  1  high while in PLAY.
new_record  output  1  high in OVER when the last game set a new high score.

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-high.
- Reset values:
  - state IDLE; score 00; hi 00; blink counter 0; blink_on 1.
  - num_1 = num_2 = 4'hF; num_3 = num_4 = 0.
  - playing = 0; new_record = 0.
- Reset asserted mid-game returns everything to these values immediately, including hi.
- Score counter (BCD):
  - Two digits, each constrained to 0..9.
  - Increment: ones 9 -> 0 with carry into tens.
  - At 99, further increments are ignored (saturates, never wraps to 00).
- State IDLE:
  - start -> PLAY. Score cleared to 00 on the same edge.
  - score_inc and game_over are ignored.
- State PLAY:
  - score_inc increments the score.
  - game_over -> OVER.
  - start is ignored.
- Game-over edge:
  - If the post-increment score is greater than hi, then hi <= score and new_record <= 1; otherwise new_record <= 0.
  - "Post-increment" means that when score_inc and game_over arrive together, the increment is applied first and the comparison uses the incremented value.
  - On this edge the blink counter is cleared and blink_on is set to 1.
- State OVER:
  - The blink counter counts 0..BLINK_DIV-1. On the cycle it wraps to 0, blink_on toggles.
  - start -> PLAY: score <= 00, new_record <= 0, blink counter <= 0, blink_on <= 1.
  - score_inc and game_over are ignored.
- Simultaneous start with game_over or score_inc:
  - In IDLE and OVER, start wins.
  - In PLAY, start is ignored and the others act normally.
- Output mapping (all outputs are registered; they reflect the state and counters one cycle after the causing edge):
  - IDLE: num_1 = num_2 = F; num_3/num_4 = hi.
  - PLAY: num_1/num_2 = score; num_3/num_4 = hi.
  - OVER: num_1/num_2 = score when blink_on, F otherwise.
  - OVER: num_3/num_4 = hi when new_record = 0 (steady); when new_record = 1 they blink in phase with the score digits.
- playing = 1 exactly when the registered state is PLAY.
- Outputs never carry the values A..E; only 0..9 and F.

Test Plan:
1. Assert rst asynchronously mid-cycle -> outputs immediately F, F, 0, 0; playing = 0; new_record = 0. Release rst, pulse start -> next cycle playing = 1 and num_1/num_2 = 0,0.
2. In PLAY, apply 9 score_inc pulses then 1 more -> num_1/num_2 read 0,9 then 1,0. Continue to 99 and apply 3 extra pulses -> digits stay 9,9.
3. Score 12 with hi 00, pulse game_over -> num_3/num_4 = 1,2 and new_record = 1. With BLINK_DIV = 4, score and hi digits alternate value/F every 4 cycles.
4. Next game: start, reach score 05, game_over -> new_record = 0; hi stays 12 steady; score digits blink 0,5 / F,F.
5. Score 07, hi 07; pulse score_inc and game_over in the same cycle -> score 08, hi 08, new_record = 1.
6. Stimulus ignored outside its state: score_inc and game_over in IDLE, start in PLAY, score_inc in OVER -> no change to score, hi or state. Then start in OVER -> PLAY, score 00, blink stopped (num_1/num_2 = 0,0 steady).
